bram_fill_ctrl: RTL and testbench
=================================

# bram_fill_ctrl

Upstream loader for the 16x2 block RAM stage. Accepts bytes over a valid/ready stream, slices each byte into 2-bit symbols LSB-first, and drives the RAM's `enable`/`write_en`/`addr_in`/`data_in` port to fill addresses 0..15 in order. Raises `done` when a full 16-symbol image has been written. Optionally checks each write against the RAM's `q_out` readback.

## Interface
Parameters:
- `BYTE_W`, 8: input stream width; must be a multiple of `SYM_W`.
- `SYM_W`, 2: RAM word width.
- `ADDR_W`, 4: RAM address width; depth is 2**`ADDR_W` = 16.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a fill; sampled only in IDLE.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  loader can accept a byte.
- `s_data`  in  `BYTE_W`  input byte.
- `bram_enable`  out  1  to RAM `enable`.
- `bram_write_en`  out  1  to RAM `write_en`.
- `bram_addr`  out  `ADDR_W`  to RAM `addr_in`.
- `bram_data`  out  `SYM_W`  to RAM `data_in`.
- `bram_q`  in  `SYM_W`  from RAM `q_out`; used only with verify.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the fill completes.
- `verify_err`  out  1  sticky mismatch flag; present only with `BRAM_FILL_VERIFY_EN`.

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE.
- **IDLE.** When `start`=1: clear the address pointer `ptr` and the symbol counter, clear `verify_err`, then go to LOAD.
- **LOAD.**
  - `s_ready`=1.
  - On `s_valid && s_ready`, capture `s_data` into the shift register and go to WRITE.
  - Gaps on `s_valid` simply hold LOAD.
- **WRITE.** Lasts SPB = `BYTE_W`/`SYM_W` = 4 cycles. In each cycle:
  - `bram_enable`=`bram_write_en`=1.
  - `bram_addr`=`ptr`.
  - `bram_data`=the shift register's low `SYM_W` bits.
  - On the edge, shift right by `SYM_W` and increment `ptr` modulo 16.
- **End of WRITE burst.**
  - If `ptr` has wrapped to 0 (16 symbols written), go to DONE.
  - Otherwise go to LOAD.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- Output rules:
  - All outputs are Moore-decoded from state and registers.
  - `bram_*` outputs are 0 outside WRITE.
  - `s_ready`=0 outside LOAD.
- `start` asserted outside IDLE is ignored.
- A fill writes exactly 16 symbols from 4 bytes. Symbol k of byte b lands at address 4b+k, with k=0 taken from bits [1:0].

## Timing
- Reset values: state=IDLE, `ptr`=0, `s_ready`=0, `bram_enable`=0, `bram_write_en`=0, `bram_addr`=0, `bram_data`=0, `busy`=0, `done`=0, `verify_err`=0.
- Reset asserted mid-operation aborts the fill:
  - No RAM write occurs in any cycle where `rst`=1.
  - The partial image is left in the RAM.
- Latencies:
  - `start` sampled at edge 0 → LOAD and `s_ready`=1 in cycle 1.
  - Byte accepted at edge A → writes in cycles A+1..A+4 → next LOAD in cycle A+5.
- With `s_valid` held high, byte b is accepted in cycle 1+5b and written in cycles 2+5b..5+5b. DONE is cycle 21 and IDLE is cycle 22.
- Throughput: 5 cycles per byte minimum.
- `s_data` is not held after acceptance; upstream may change it the following cycle.

## Configuration
- Macro: `BRAM_FILL_VERIFY_EN`.
- **Defined:**
  - A write in cycle W records the expected symbol and sets a check-pending flag.
  - In cycle W+1, `bram_q` is compared with the expected symbol. The RAM read address follows the last write address, so `q_out` shows the written symbol one cycle later.
  - A mismatch sets `verify_err`. It stays high until the next accepted `start` or `rst`.
  - The check of the final write happens in the DONE cycle.
- **Undefined:**
  - `verify_err` and its registers are absent.
  - `bram_q` is unused.
  - All other behaviour is identical.

## Structure
- Package `bram_fill_pkg` holds:
  - the state enum (IDLE, LOAD, WRITE, DONE);
  - the constants SPB = `BYTE_W`/`SYM_W` and DEPTH = 2**`ADDR_W`;
  - the default widths.
- One sub-module is natural: `byte_sym_shifter`, the load/shift register presenting the current symbol. Address, counter and FSM stay in the top.

## Test plan
- **Basic fill.** `start`, then bytes 0xE4, 0x1B, 0xFF, 0x00 with `s_valid` held high.
  - Required RAM contents: addr 0..3 = 0,1,2,3; addr 4..7 = 3,2,1,0; addr 8..11 = 3; addr 12..15 = 0.
  - `done` high in cycle 21 only.
- **Backpressure.** Insert 3-cycle `s_valid` gaps before each byte.
  - Required: same RAM contents as basic fill.
  - `bram_write_en` is never high while in LOAD.
  - Each gap delays `done` by exactly 3 cycles.
- **Start while busy.** Pulse `start` during the second WRITE burst.
  - Required: ignored; `ptr` continues 4..7; one `done` pulse.
- **Reset mid-fill.** Assert `rst` during the write to addr 6.
  - Required: addr 6 is not written.
  - All outputs are at reset values the next cycle.
  - A new `start` rewrites addresses from 0.
- **Verify error (macro defined).** Hold `bram_q`=0 and load bytes 0xFF ×4.
  - Required: `verify_err` rises in cycle 3 and stays high through DONE.
  - The next `start` clears it.
  - With a correct RAM model attached, `verify_err` stays 0.

Source files
------------

// File: rtl/bram_fill_pkg.sv
// Shared types and default geometry for the 16x2 block RAM fill loader.
package bram_fill_pkg;

    localparam int DEF_BYTE_W = 8;
    localparam int DEF_SYM_W  = 2;
    localparam int DEF_ADDR_W = 4;
    localparam int SPB        = DEF_BYTE_W / DEF_SYM_W;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } fill_state_t;

endpackage

// File: rtl/bram_fill_ctrl_byte_sym_shifter.sv
// Byte holding register that presents one RAM symbol at a time, LSB-first.
module byte_sym_shifter
    import bram_fill_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int SYM_W  = DEF_SYM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] din,
    output logic [SYM_W-1:0]  sym
);

    logic [BYTE_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr >> SYM_W;
        end
    end

    assign sym = sr[SYM_W-1:0];

endmodule

// File: rtl/bram_fill_ctrl.sv
// Streams bytes into a 16x2 block RAM, one 2-bit symbol per cycle, LSB-first.
// Optional write readback checking is enabled with BRAM_FILL_VERIFY_EN.
module bram_fill_ctrl
    import bram_fill_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int SYM_W  = DEF_SYM_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    output logic              bram_enable,
    output logic              bram_write_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [SYM_W-1:0]  bram_data,
    input  logic [SYM_W-1:0]  bram_q,
    output logic              busy,
    output logic              done
`ifdef BRAM_FILL_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    localparam int SYM_PER_BYTE = BYTE_W / SYM_W;
    localparam int CNT_W        = (SYM_PER_BYTE > 1) ? $clog2(SYM_PER_BYTE) : 1;
    localparam logic [CNT_W-1:0]  LAST_SYM  = CNT_W'(SYM_PER_BYTE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fill_state_t       state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  sym_cnt;
    logic              accept;
    logic              in_write;
    logic              last_sym;
    logic              fill_start;
    logic [SYM_W-1:0]  cur_sym;

    assign fill_start = (state == IDLE) && start;
    assign accept     = (state == LOAD) && s_valid;
    assign in_write   = (state == WRITE);
    assign last_sym   = (sym_cnt == LAST_SYM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fill_start) begin
            ptr     <= '0;
            sym_cnt <= '0;
        end else if (in_write) begin
            ptr     <= ptr + 1'b1;
            sym_cnt <= last_sym ? '0 : sym_cnt + 1'b1;
        end
    end

    // The final symbol of a burst landing on the top address means the image is full.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (s_valid) state_next = WRITE;
            WRITE:   if (last_sym) state_next = (ptr == LAST_ADDR) ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    byte_sym_shifter #(
        .BYTE_W(BYTE_W),
        .SYM_W (SYM_W)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(in_write),
        .din  (s_data),
        .sym  (cur_sym)
    );

    // RAM strobes are masked by rst so an aborted fill never lands a write.
    always_comb begin
        s_ready       = (state == LOAD);
        busy          = (state != IDLE);
        done          = (state == DONE);
        bram_enable   = in_write && !rst;
        bram_write_en = in_write && !rst;
        bram_addr     = bram_enable ? ptr : '0;
        bram_data     = bram_enable ? cur_sym : '0;
    end

`ifdef BRAM_FILL_VERIFY_EN
    logic             chk_pend;
    logic [SYM_W-1:0] exp_sym;
    logic             err_sticky;
    logic             mismatch;

    // The RAM shows the last written word on q_out one cycle after the write.
    assign mismatch = chk_pend && (bram_q != exp_sym);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_pend   <= 1'b0;
            exp_sym    <= '0;
            err_sticky <= 1'b0;
        end else begin
            chk_pend <= bram_write_en;
            exp_sym  <= cur_sym;
            if (fill_start) begin
                err_sticky <= 1'b0;
            end else if (mismatch) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign verify_err = err_sticky || mismatch;
`else
    logic unused_bram_q;
    assign unused_bram_q = ^bram_q;
`endif

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// Randomized scoreboard bench for bram_fill_ctrl; expected RAM writes are queued
// by the stimulus and consumed by an independent write monitor.
module tb_bram_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       bram_enable;
    logic       bram_write_en;
    logic [3:0] bram_addr;
    logic [1:0] bram_data;
    logic [1:0] bram_q;
    logic       busy;
    logic       done;
`ifdef BRAM_FILL_VERIFY_EN
    logic       verify_err;
`endif

    bram_fill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .bram_enable  (bram_enable),
        .bram_write_en(bram_write_en),
        .bram_addr    (bram_addr),
        .bram_data    (bram_data),
        .bram_q       (bram_q),
        .busy         (busy),
        .done         (done)
`ifdef BRAM_FILL_VERIFY_EN
        ,
        .verify_err   (verify_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] exp_addr_q[$];
    logic [1:0] exp_data_q[$];
    logic [1:0] tb_ram[16];
    int done_count = 0;
    int done_cyc = 0;
    int err_first_cyc = -1;
    int err_hi_cycles = 0;
    bit err_at_done = 1'b0;

    // Behavioural RAM readback: q_out follows the most recently written word.
    bit q_zero = 1'b0;
    logic [1:0] q_reg = 2'b00;
    always @(posedge clk) if (bram_enable && bram_write_en) q_reg <= bram_data;
    assign bram_q = q_zero ? 2'b00 : q_reg;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write seen must match the next queued expectation.
    always @(negedge clk) begin
        if (bram_write_en) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, required no write", bram_addr, bram_data);
            end else begin
                checkOutput("write_addr", bram_addr, exp_addr_q.pop_front());
                checkOutput("write_data", bram_data, exp_data_q.pop_front());
                checkOutput("write_enable", bram_enable, 1);
            end
            checkOutput("no_write_in_load", s_ready, 0);
            tb_ram[bram_addr] = bram_data;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
`ifdef BRAM_FILL_VERIFY_EN
        if (verify_err) begin
            err_hi_cycles++;
            if (err_first_cyc < 0) err_first_cyc = cyc;
        end
        if (done) err_at_done = verify_err;
`endif
    end

    // Drives one fill: data holds byte b at [8b+:8], gaps holds the idle-valid
    // cycles before byte b at [4b+:4]. Relative cycle 0 is the start cycle.
    task automatic applyStimulus(input logic [31:0] data, input logic [15:0] gaps,
                                 input int busy_start_rel, input int rst_rel, input int n_writes,
                                 output int done_rel, output int start_cyc);
        int b;
        int gap_left;
        int rel;
        int dc0;
        bit finished;
        for (int i = 0; i < n_writes; i++) begin
            exp_addr_q.push_back(4'(i));
            exp_data_q.push_back(data[2*i +: 2]);
        end
        dc0 = done_count;
        done_rel = -1;
        finished = 1'b0;
        b = 0;
        gap_left = int'(gaps[3:0]);
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            rel = cyc - start_cyc;
            start = (rel == busy_start_rel);
            if (rel == rst_rel) begin
                rst = 1'b1;
                s_valid = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                finished = 1'b1;
                break;
            end
            if (done_count != dc0) begin
                done_rel = done_cyc - start_cyc;
                finished = 1'b1;
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_done", done, 0);
                break;
            end
            if (rel == 1) begin
                checkOutput("load_ready", s_ready, 1);
                checkOutput("load_busy", busy, 1);
`ifdef BRAM_FILL_VERIFY_EN
                checkOutput("verr_cleared", verify_err, 0);
                err_first_cyc = -1;
                err_hi_cycles = 0;
`endif
            end
            if (s_ready && b < 4) begin
                if (gap_left > 0) begin
                    s_valid = 1'b0;
                    s_data = 8'($urandom);
                    gap_left--;
                end else begin
                    s_valid = 1'b1;
                    s_data = data[8*b +: 8];
                    b++;
                    if (b < 4) gap_left = int'(gaps[4*b +: 4]);
                end
            end else begin
                s_valid = 1'b0;
                s_data = 8'($urandom);
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL fill_timeout: got no done within 300 cycles, required done");
        end
        if (rst_rel < 0) begin
            repeat (2) @(posedge clk);
            #1;
            checkOutput("done_pulses", done_count - dc0, 1);
        end
    endtask

    function automatic int reqBasic(input int a);
        if (a < 4) return a;
        if (a < 8) return 7 - a;
        if (a < 12) return 3;
        return 0;
    endfunction

    task automatic clearRam();
        for (int i = 0; i < 16; i++) tb_ram[i] = 2'bxx;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
        checkOutput({tag, "_enable"}, bram_enable, 0);
        checkOutput({tag, "_write_en"}, bram_write_en, 0);
        checkOutput({tag, "_addr"}, bram_addr, 0);
        checkOutput({tag, "_data"}, bram_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
`ifdef BRAM_FILL_VERIFY_EN
        checkOutput({tag, "_verify_err"}, verify_err, 0);
`endif
    endtask

    initial begin
        int dr;
        int sc;
        logic [31:0] rdata;
        logic [15:0] rgaps;
        int gsum;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;

        clearRam();
        applyStimulus(32'h00FF1BE4, 16'h0000, -1, -1, 16, dr, sc);
        checkOutput("basic_done_cycle", dr, 21);
        for (int i = 0; i < 16; i++) checkOutput("basic_ram", tb_ram[i], reqBasic(i));

        clearRam();
        applyStimulus(32'h00FF1BE4, 16'h3333, -1, -1, 16, dr, sc);
        checkOutput("backpressure_done_cycle", dr, 33);
        for (int i = 0; i < 16; i++) checkOutput("backpressure_ram", tb_ram[i], reqBasic(i));

        rdata = $urandom;
        applyStimulus(rdata, 16'h0000, 8, -1, 16, dr, sc);
        checkOutput("busy_start_done_cycle", dr, 21);

        rdata = $urandom;
        applyStimulus(rdata, 16'h0000, -1, 9, 6, dr, sc);
        checkResetOutputs("abort");
        checkOutput("abort_queue_drained", exp_addr_q.size(), 0);

        for (int n = 0; n < 6; n++) begin
            rdata = $urandom;
            gsum = 0;
            for (int k = 0; k < 4; k++) begin
                rgaps[4*k +: 4] = 4'($urandom_range(0, 3));
                gsum += int'(rgaps[4*k +: 4]);
            end
            clearRam();
            applyStimulus(rdata, rgaps, -1, -1, 16, dr, sc);
            checkOutput("random_done_cycle", dr, 21 + gsum);
            for (int i = 0; i < 16; i++) checkOutput("random_ram", tb_ram[i], rdata[2*i +: 2]);
        end

`ifdef BRAM_FILL_VERIFY_EN
        q_zero = 1'b1;
        applyStimulus(32'hFFFFFFFF, 16'h0000, -1, -1, 16, dr, sc);
        checkOutput("verr_rise_cycle", err_first_cyc - sc, 3);
        checkOutput("verr_at_done", err_at_done, 1);
        q_zero = 1'b0;
        rdata = $urandom;
        applyStimulus(rdata, 16'h0000, -1, -1, 16, dr, sc);
        checkOutput("verr_clean_cycles", err_hi_cycles, 0);
`endif

        checkOutput("final_queue_empty", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
